// File: rtl/nibble_add_pkg.sv
// Shared constants and state encoding for the nibble-serial adder and its slice.
package nibble_add_pkg;

  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned MAX_NIBBLES = 16;
  localparam int unsigned IDX_W       = $clog2(MAX_NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit combinational carry-lookahead adder slice.
module cla4_slice
  import nibble_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] S,
  output logic                Cout
);

  logic [NIBBLE_W-1:0] w_g;
  logic [NIBBLE_W-1:0] w_p;
  logic [NIBBLE_W:0]   w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Every carry is expanded directly from generate/propagate terms, no ripple.
  assign w_c[0] = Cin;
  assign w_c[1] = w_g[0] | (w_p[0] & Cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

  assign S    = w_p ^ w_c[NIBBLE_W-1:0];
  assign Cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// W-bit adder streaming one nibble per cycle through cla4_slice, valid/ready on both sides.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add the op port (op=1 computes a-b).
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  input  logic                         cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic                         op,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout,
  output logic                         ovf
);

  localparam int unsigned W = NIBBLE_W * NIBBLES;

  state_t               r_state, w_state_next;
  logic [W-1:0]         r_a, r_b, r_sum;
  logic [W-1:0]         w_b_load, w_sum_next;
  logic                 r_carry, r_cout, r_ovf;
  logic                 w_c_load;
  logic [IDX_W-1:0]     r_idx;
  logic                 w_last;
  logic [NIBBLE_W-1:0]  w_a_nib, w_b_nib, w_s_nib;
  logic                 w_c_nib;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign w_b_load = op ? ~b : b;
  assign w_c_load = op ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_nib = r_a[k*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  cla4_slice u_slice (
    .A    (w_a_nib),
    .B    (w_b_nib),
    .Cin  (r_carry),
    .S    (w_s_nib),
    .Cout (w_c_nib)
  );

  always_comb begin
    w_sum_next = r_sum;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (r_idx == IDX_W'(k)) w_sum_next[k*NIBBLE_W +: NIBBLE_W] = w_s_nib;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // cout/ovf are separate from the working carry so outputs only move on RUN edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_c_nib;
          r_cout  <= w_c_nib;
          if (w_last) r_ovf <= r_a[W-1] ^ r_b[W-1] ^ w_s_nib[NIBBLE_W-1] ^ w_c_nib;
          else        r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) against an arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op_s = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .op        (op_s),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: {ovf, cout, sum} from plain W+1-bit arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic mop);
    logic [W-1:0] beff;
    logic [W:0]   full;
    logic         c0, v;
    beff = mop ? ~mb : mb;
    c0   = mop ? 1'b1 : mcin;
    full = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, c0};
    v    = (ma[W-1] == beff[W-1]) && (full[W-1] != ma[W-1]);
    return {v, full};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                        input logic top, input int unsigned pre_stall,
                        output int lat, output bit tmo);
    int guard;
    tmo = 1'b0;
    in_valid = 1'b0;
    repeat (pre_stall) @(negedge clk);
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; op_s = top; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) tmo = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op_s = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) tmo = 1'b1;
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want rdy=1 vld=0 sum=0000 cout=0 ovf=0",
               in_ready, out_valid, sum, cout, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int lat; bit tmo;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, lat, tmo);
    tests++;
    if (tmo || lat != 5) begin
      fails++;
      $display("FAIL basic_latency: got %0d edges (timeout=%0b), want 5", lat, tmo);
    end
    tests++;
    if ({ovf, cout, sum} !== {1'b0, 1'b0, 16'h5555}) begin
      fails++;
      $display("FAIL basic_result: got sum=%h cout=%b ovf=%b, want 5555 0 0", sum, cout, ovf);
    end
    finish_op();
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL basic_handshake: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_carry_ripple();
    int lat; bit tmo;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, lat, tmo);
    tests++;
    if (tmo || {ovf, cout, sum} !== {1'b0, 1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL ripple_wrap: got sum=%h cout=%b ovf=%b tmo=%0b, want 0000 1 0", sum, cout, ovf, tmo);
    end
    finish_op();
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, lat, tmo);
    tests++;
    if (tmo || {ovf, cout, sum} !== {1'b1, 1'b0, 16'h8000}) begin
      fails++;
      $display("FAIL ripple_ovf: got sum=%h cout=%b ovf=%b tmo=%0b, want 8000 0 1", sum, cout, ovf, tmo);
    end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat; bit tmo; int guard;
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 0, lat, tmo);
    tests++;
    if (tmo) begin
      fails++;
      $display("FAIL bp_start: timeout waiting for out_valid");
    end
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; cin = 1'b0; op_s = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h0100}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b cout=%b sum=%h, want 1 0 0 0100",
                 i, out_valid, in_ready, cout, sum);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL bp_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept: got rdy=%b, want 0 after second op accepted", in_ready);
    end
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    tests++;
    if (!out_valid || sum !== 16'h2222) begin
      fails++;
      $display("FAIL bp_second: got vld=%b sum=%h, want 1 2222", out_valid, sum);
    end
    finish_op();
  endtask

  task automatic test_reset_mid_run();
    int lat; bit tmo;
    @(negedge clk);
    a = 16'hABCD; b = 16'h1357; cin = 1'b1; op_s = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midrun_reset: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want 1 0 0000 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0, lat, tmo);
    tests++;
    if (tmo || lat != 5 || sum !== 16'h0003) begin
      fails++;
      $display("FAIL midrun_after: got sum=%h lat=%0d tmo=%0b, want 0003 5 0", sum, lat, tmo);
    end
    finish_op();
  endtask

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  task automatic test_subtract();
    int lat; bit tmo;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, lat, tmo);
    tests++;
    if (tmo || {cout, sum} !== {1'b0, 16'hFFFE}) begin
      fails++;
      $display("FAIL sub_borrow: got sum=%h cout=%b, want FFFE 0", sum, cout);
    end
    finish_op();
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0, lat, tmo);
    tests++;
    if (tmo || {ovf, sum} !== {1'b1, 16'h7FFF}) begin
      fails++;
      $display("FAIL sub_ovf: got sum=%h ovf=%b, want 7FFF 1", sum, ovf);
    end
    finish_op();
  endtask
`endif

  task automatic test_random();
    int lat; bit tmo;
    logic [W-1:0] ra, rb;
    logic rc, rop;
    logic [W+1:0] exp;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      rop = 1'($urandom);
`else
      rop = 1'b0;
`endif
      exp = model(ra, rb, rc, rop);
      run_op(ra, rb, rc, rop, $urandom_range(0, 2), lat, tmo);
      tests++;
      if (tmo || lat != 5 || {ovf, cout, sum} !== exp) begin
        fails++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b op=%b: got ovf=%b cout=%b sum=%h lat=%0d tmo=%0b, want ovf=%b cout=%b sum=%h lat=5",
                 n, ra, rb, rc, rop, ovf, cout, sum, lat, tmo, exp[W+1], exp[W], exp[W-1:0]);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tests++;
      if ({out_valid, ovf, cout, sum} !== {1'b1, exp}) begin
        fails++;
        $display("FAIL random_stall[%0d]: got vld=%b ovf=%b cout=%b sum=%h, want 1 %b %b %h",
                 n, out_valid, ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
      end
      finish_op();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_backpressure();
    test_reset_mid_run();
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    test_subtract();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
